// File: rtl/unsigned_mul_8x8_pkg.sv
// Shared widths, array count and FSM states for the 8x8 half-adder-array reducer.
package unsigned_mul_8x8_pkg;
  localparam int B_W        = 7;
  localparam int T_W        = 9;
  localparam int NUM_ARRAYS = 4;
  localparam int CNT_W      = $clog2(NUM_ARRAYS);
  localparam int ACC_W_DEF  = 17;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;
endpackage

// File: rtl/ha_array_weight.sv
// Weighted value of one half-adder array: t at 4^k, b at 4^k * 4.
module ha_array_weight
  import unsigned_mul_8x8_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [B_W-1:0]   b,
  input  logic [T_W-1:0]   t,
  input  logic [CNT_W-1:0] k,
  output logic [ACC_W-1:0] v
);
  logic [ACC_W-1:0] t_ext, b_ext;

  assign t_ext = ACC_W'(t) << {k, 1'b0};
  assign b_ext = (ACC_W'(b) << 2) << {k, 1'b0};
  assign v     = t_ext + b_ext;
endmodule

// File: rtl/unsigned_mul_8x8_ha_array_reducer.sv
// Captures four half-adder arrays, sums their weighted values one per cycle, saturates to OUT_W.
module unsigned_mul_8x8_ha_array_reducer
  import unsigned_mul_8x8_pkg::*;
#(
  parameter int OUT_W = 16,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [B_W-1:0]   ha_array_0_b,
  input  logic [B_W-1:0]   ha_array_1_b,
  input  logic [B_W-1:0]   ha_array_2_b,
  input  logic [B_W-1:0]   ha_array_3_b,
  input  logic [T_W-1:0]   ha_array_0_t,
  input  logic [T_W-1:0]   ha_array_1_t,
  input  logic [T_W-1:0]   ha_array_2_t,
  input  logic [T_W-1:0]   ha_array_3_t,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] product,
  output logic             ovf
);
  localparam logic [ACC_W:0] MAX_OUT = (ACC_W+1)'((64'd1 << OUT_W) - 64'd1);

  logic [NUM_ARRAYS-1:0][B_W-1:0] b_in, b_q;
  logic [NUM_ARRAYS-1:0][T_W-1:0] t_in, t_q;
  state_e                         state, state_nxt;
  logic [CNT_W-1:0]               cnt;
  logic [ACC_W-1:0]               acc, v_sel;
  logic                           accept, sat;

  assign b_in = {ha_array_3_b, ha_array_2_b, ha_array_1_b, ha_array_0_b};
  assign t_in = {ha_array_3_t, ha_array_2_t, ha_array_1_t, ha_array_0_t};

  // Single weight unit, steered to the array selected by cnt.
  ha_array_weight #(.ACC_W(ACC_W)) u_weight (
    .b (b_q[cnt]),
    .t (t_q[cnt]),
    .k (cnt),
    .v (v_sel)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = ACC;
      ACC:     if (cnt == CNT_W'(NUM_ARRAYS-1)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q <= '0;
      t_q <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      b_q <= b_in;
      t_q <= t_in;
      acc <= '0;
      cnt <= '0;
    end else if (state == ACC) begin
      acc <= acc + v_sel;
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Outputs are derived from the held accumulator and gated to zero outside DONE.
  assign sat     = ({1'b0, acc} > MAX_OUT);
  assign ovf     = out_valid & sat;
  assign product = !out_valid ? '0 : (sat ? '1 : OUT_W'(acc));
endmodule

// File: tb/tb_unsigned_mul_8x8_ha_array_reducer.sv
// Directed + randomized check of the reducer against a per-bit weight-sum model.
module tb_unsigned_mul_8x8_ha_array_reducer;
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0][6:0]  b_in = '0;
  logic [3:0][8:0]  t_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [15:0]      product;
  logic             ovf;

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;
  int n_done = 0;

  typedef struct {int due; logic [15:0] p; logic o;} exp_t;
  exp_t q[$];

  unsigned_mul_8x8_ha_array_reducer #(.OUT_W(16), .ACC_W(17)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ha_array_0_b(b_in[0]), .ha_array_1_b(b_in[1]), .ha_array_2_b(b_in[2]), .ha_array_3_b(b_in[3]),
    .ha_array_0_t(t_in[0]), .ha_array_1_t(t_in[1]), .ha_array_2_t(t_in[2]), .ha_array_3_t(t_in[3]),
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .ovf(ovf)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Each set bit contributes its own power of two.
  function automatic int model_sum(input logic [3:0][6:0] bv, input logic [3:0][8:0] tv);
    int s = 0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 9; i++) if (tv[k][i]) s += (1 << (2*k + i));
      for (int i = 0; i < 7; i++) if (bv[k][i]) s += (1 << (2*k + i + 2));
    end
    return s;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_product", 32'(product), 0);
      chk("rst_ovf", 32'(ovf), 0);
    end else begin
      bit model_ready, exp_valid;
      model_ready = (q.size() == 0);
      exp_valid   = !model_ready && (edge_cnt >= q[0].due);
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("in_ready", 32'(in_ready), 32'(model_ready));
      if (exp_valid && out_valid) begin
        chk("model_product", 32'(product), 32'(q[0].p));
        chk("model_ovf", 32'(ovf), 32'(q[0].o));
      end else if (!out_valid) begin
        chk("idle_product", 32'(product), 0);
        chk("idle_ovf", 32'(ovf), 0);
      end
      if (exp_valid && out_ready) begin
        void'(q.pop_front());
        n_done++;
      end
      if (model_ready && in_valid) begin
        exp_t e;
        int s;
        s   = model_sum(b_in, t_in);
        e.due = edge_cnt + 5;
        e.o = (s > 65535);
        e.p = e.o ? 16'hFFFF : 16'(s);
        q.push_back(e);
      end
    end
  end

  task automatic scramble();
    b_in = 28'($urandom);
    t_in = {4'($urandom), 32'($urandom)};
  endtask

  task automatic send(input logic [3:0][6:0] bv, input logic [3:0][8:0] tv);
    int n = 0;
    b_in = bv; t_in = tv; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("accept_timeout", 0, 1);
    @(posedge clk); #2;
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic run_beat(input logic [3:0][6:0] bv, input logic [3:0][8:0] tv,
                          input logic [15:0] ep, input logic eo, input string name);
    send(bv, tv);
    wait_valid(name);
    chk({name, "_product"}, 32'(product), 32'(ep));
    chk({name, "_ovf"}, 32'(ovf), 32'(eo));
    @(posedge clk); #2 out_ready = 1'b1;
    @(posedge clk); #2 out_ready = 1'b0;
  endtask

  initial begin
    logic [3:0][6:0] bv;
    logic [3:0][8:0] tv;
    int base, cyc;

    #3;
    chk("por_out_valid", 32'(out_valid), 0);
    chk("por_product", 32'(product), 0);
    chk("por_ovf", 32'(ovf), 0);
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
    chk("por_in_ready", 32'(in_ready), 1);

    bv = '0; tv = '0;
    run_beat(bv, tv, 16'd0, 1'b0, "zero");
    tv[0][0] = 1'b1;
    run_beat(bv, tv, 16'd1, 1'b0, "t0b0");
    bv = '0; tv = '0; bv[3][6] = 1'b1;
    run_beat(bv, tv, 16'd16384, 1'b0, "b3b6");
    bv = '1; tv = '1;
    run_beat(bv, tv, 16'hFFFF, 1'b1, "all_ones");
    bv = '0; tv = '0; tv[3] = 9'h1C0; bv[3] = 7'h70; tv[0] = 9'h1FF; tv[2] = 9'h1E0;
    run_beat(bv, tv, 16'hFFFF, 1'b0, "sum_65535");
    bv = '0; tv = '0; tv[3] = 9'h1C0; bv[3] = 7'h70; tv[2] = 9'h100; bv[2] = 7'h40;
    run_beat(bv, tv, 16'hFFFF, 1'b1, "sum_65536");

    // Stall in DONE, then release with the next beat already waiting.
    bv = '0; tv = '0; tv[2] = 9'h100; bv[1] = 7'h01;
    send(bv, tv);
    wait_valid("stall");
    for (int i = 0; i < 3; i++) begin
      chk("stall_product", 32'(product), 32'd4112);
      chk("stall_in_ready", 32'(in_ready), 0);
      @(negedge clk);
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    bv = '0; tv = '0; tv[0][0] = 1'b1;
    b_in = bv; t_in = tv; in_valid = 1'b1;
    @(posedge clk); #2 out_ready = 1'b0;
    @(negedge clk);
    chk("release_idle_in_ready", 32'(in_ready), 1);
    chk("release_idle_out_valid", 32'(out_valid), 0);
    @(posedge clk); #2 in_valid = 1'b0; scramble();
    wait_valid("after_stall");
    chk("after_stall_product", 32'(product), 1);
    @(posedge clk); #2 out_ready = 1'b1;
    @(posedge clk); #2 out_ready = 1'b0;

    // Reset mid-accumulation.
    bv = '1; tv = '1;
    send(bv, tv);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("rst_acc_out_valid", 32'(out_valid), 0);
    chk("rst_acc_product", 32'(product), 0);
    @(negedge clk); @(posedge clk); #2 rst_n = 1'b1;
    chk("rst_acc_in_ready", 32'(in_ready), 1);
    repeat (8) @(posedge clk);
    #2;

    // Reset while holding a result.
    send(bv, tv);
    wait_valid("rst_done");
    #1 rst_n = 1'b0;
    #1;
    chk("rst_done_out_valid", 32'(out_valid), 0);
    chk("rst_done_product", 32'(product), 0);
    chk("rst_done_ovf", 32'(ovf), 0);
    @(negedge clk); @(posedge clk); #2 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #2;

    base = n_done;
    cyc = 0;
    while (n_done - base < 1000 && cyc < 30000) begin
      @(posedge clk); #2;
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      if ($urandom_range(7) == 0) begin b_in = '1; t_in = '1; end
      else scramble();
      cyc++;
    end
    if (cyc >= 30000) chk("random_timeout", 32'(n_done - base), 1000);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #2 out_ready = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
